// File: rtl/trace_request_queue_if.sv
// Handshake bundle between parser, trace_request_queue and memory controller.
// master drives entries/flush/out_ready; slave is the queue itself.
interface trace_request_queue_if #(
    parameter int ADDR_WIDTH  = 36,
    parameter int MEMOP_WIDTH = 2,
    parameter int TIME_WIDTH  = 12,
    parameter int CYCLE_WIDTH = 64,
    parameter int DEPTH       = 16
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = TIME_WIDTH + MEMOP_WIDTH + ADDR_WIDTH;

    logic                   in_valid;
    logic                   in_ready;
    logic [DW-1:0]          in_data;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [TIME_WIDTH-1:0]  out_time;
    logic [MEMOP_WIDTH-1:0] out_op;
    logic [ADDR_WIDTH-1:0]  out_addr;
    logic [CYCLE_WIDTH-1:0] cycle;
    logic [CW-1:0]          count;
    logic                   empty;
    logic                   full;
    logic                   order_err;
    logic [31:0]            stat_issued;
    logic [31:0]            stat_stall;
    logic [CW-1:0]          stat_max_occ;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_time, out_op, out_addr, cycle, count,
               empty, full, order_err, stat_issued, stat_stall, stat_max_occ
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_time, out_op, out_addr, cycle, count,
               empty, full, order_err, stat_issued, stat_stall, stat_max_occ
    );
endinterface

// File: rtl/trace_request_queue.sv
// Timestamp-gated trace FIFO: head released once cycle >= its time (earliest pop one edge after push);
// in_ready = !full && !flush, no bypass when full. TRQ_STATS_EN builds the statistics counters.
module trace_request_queue #(
    parameter int ADDR_WIDTH  = 36,
    parameter int MEMOP_WIDTH = 2,
    parameter int TIME_WIDTH  = 12,
    parameter int CYCLE_WIDTH = 64,
    parameter int DEPTH       = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    trace_request_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [TIME_WIDTH-1:0]  t;
        logic [MEMOP_WIDTH-1:0] op;
        logic [ADDR_WIDTH-1:0]  addr;
    } entry_t;

    entry_t                 mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count_q;
    logic [CYCLE_WIDTH-1:0] cycle_q;
    logic [TIME_WIDTH-1:0]  last_time;
    logic                   order_err_q;

    entry_t in_ent;
    entry_t head;
    logic   empty_w, full_w, in_ready_w, out_valid_w, push, pop;

    assign in_ent      = entry_t'(bus.in_data);
    assign empty_w     = (count_q == '0);
    assign full_w      = (count_q == CW'(DEPTH));
    assign head        = empty_w ? entry_t'('0) : mem[rd_ptr];
    assign in_ready_w  = !full_w && !bus.flush;
    assign out_valid_w = !empty_w && (cycle_q >= CYCLE_WIDTH'(head.t));
    assign push        = bus.in_valid && in_ready_w;
    assign pop         = out_valid_w && bus.out_ready && !bus.flush;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_time  = head.t;
    assign bus.out_op    = head.op;
    assign bus.out_addr  = head.addr;
    assign bus.cycle     = cycle_q;
    assign bus.count     = count_q;
    assign bus.empty     = empty_w;
    assign bus.full      = full_w;
    assign bus.order_err = order_err_q;

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= in_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            cycle_q     <= '0;
            last_time   <= '0;
            order_err_q <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            if (bus.flush) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count_q     <= '0;
                last_time   <= '0;
                order_err_q <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    last_time <= in_ent.t;
                    // Out-of-order entries are still queued; they simply become eligible at once.
                    if (in_ent.t < last_time) begin
                        order_err_q <= 1'b1;
                    end
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

`ifdef TRQ_STATS_EN
    logic [31:0]   issued_q;
    logic [31:0]   stall_q;
    logic [CW-1:0] max_occ_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued_q  <= '0;
            stall_q   <= '0;
            max_occ_q <= '0;
        end else begin
            if (pop && (issued_q != '1)) begin
                issued_q <= issued_q + 1'b1;
            end
            if (out_valid_w && !bus.out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (count_q > max_occ_q) begin
                max_occ_q <= count_q;
            end
        end
    end

    assign bus.stat_issued  = issued_q;
    assign bus.stat_stall   = stall_q;
    assign bus.stat_max_occ = max_occ_q;
`else
    assign bus.stat_issued  = '0;
    assign bus.stat_stall   = '0;
    assign bus.stat_max_occ = '0;
`endif
endmodule

// File: tb/tb_trace_request_queue.sv
// Scoreboard bench for trace_request_queue: driver queues expected entries, negedge monitor checks pops.
module tb_trace_request_queue;
    localparam int AW = 36;
    localparam int OW = 2;
    localparam int TW = 12;
    localparam int YW = 64;
    localparam int DEPTH = 16;
    localparam int DW = TW + OW + AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pops_seen = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    trace_request_queue_if #(.ADDR_WIDTH(AW), .MEMOP_WIDTH(OW), .TIME_WIDTH(TW),
                             .CYCLE_WIDTH(YW), .DEPTH(DEPTH)) bus ();

    trace_request_queue #(.ADDR_WIDTH(AW), .MEMOP_WIDTH(OW), .TIME_WIDTH(TW),
                          .CYCLE_WIDTH(YW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one entry for one edge; acc says whether the bench expects it to be taken.
    task automatic push(input logic [TW-1:0] t, input logic [OW-1:0] op,
                        input logic [AW-1:0] a, input bit acc);
        bus.in_valid = 1'b1;
        bus.in_data  = {t, op, a};
        check("in_ready_at_push", bus.in_ready, acc);
        if (acc) exp_q.push_back({t, op, a});
        tick();
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && !bus.flush && bus.out_valid && bus.out_ready) begin
            pops_seen++;
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 1'b1, 1'b0);
            end else begin
                check("pop_data", {bus.out_time, bus.out_op, bus.out_addr}, exp_q.pop_front());
                check("pop_eligible", (YW'(bus.out_time) <= bus.cycle), 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_count", bus.count, 0);
        check("rst_cycle", bus.cycle, 0);
        check("rst_order_err", bus.order_err, 0);
        check("rst_out_fields", {bus.out_time, bus.out_op, bus.out_addr}, 0);
        check("rst_stat_issued", bus.stat_issued, 0);
        check("rst_stat_stall", bus.stat_stall, 0);
        check("rst_stat_max", bus.stat_max_occ, 0);

        // Timestamp gating: time 5 pushed at cycle 1
        tick();
        check("cycle_one", bus.cycle, 1);
        bus.out_ready = 1'b1;
        push(12'd5, 2'd1, 36'h0_0000_1A00, 1);
        repeat (3) begin
            check("gate_not_yet", bus.out_valid, 0);
            tick();
        end
        check("gate_cycle", bus.cycle, 5);
        check("gate_valid", bus.out_valid, 1);
        check("gate_op", bus.out_op, 1);
        check("gate_addr", bus.out_addr, 36'h1A00);
        tick();
        check("gate_empty_after", bus.empty, 1);

        // Fill to full with out_ready low
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(12'd0, OW'(i), AW'(100 + i), 1);
        check("fill_full", bus.full, 1);
        check("fill_count", bus.count, 16);
        check("fill_in_ready", bus.in_ready, 0);
        push(12'd0, 2'd3, 36'hDEAD, 0);
        check("fill_17th_rejected", bus.count, 16);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("one_pop_count", bus.count, 15);
        check("one_pop_in_ready", bus.in_ready, 1);

        // Drop to 8, then 40 simultaneous push/pop pairs
        bus.out_ready = 1'b1;
        repeat (7) tick();
        check("count_eight", bus.count, 8);
        for (int i = 0; i < 40; i++) begin
            push(12'd0, OW'(i + 1), AW'(1000 + i), 1);
            check("pair_count", bus.count, 8);
        end
        n = 0;
        while (!bus.empty && n < 20) begin
            tick();
            n++;
        end
        check("drain_empty", bus.empty, 1);
        bus.out_ready = 1'b0;

        // Ordering error
        push(12'd400, 2'd2, 36'h111, 1);
        push(12'd390, 2'd3, 36'h222, 1);
        check("order_err_set", bus.order_err, 1);
        check("order_count", bus.count, 2);
        check("order_not_eligible", bus.out_valid, 0);
        n = 0;
        while (!bus.out_valid && n < 1000) begin
            tick();
            n++;
        end
        check("order_rise_cycle", bus.cycle, 400);
        check("order_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        check("order_both_issued", bus.empty, 1);
        check("order_err_sticky", bus.order_err, 1);
        push(12'd0, 2'd0, 36'h333, 1);
        check("late_entry_valid", bus.out_valid, 1);
        bus.flush = 1'b1;
        #1;
        check("flush_in_ready_low", bus.in_ready, 0);
        exp_q.delete();
        tick();
        bus.flush = 1'b0;
        #1;
        check("flush_order_err", bus.order_err, 0);
        check("flush_count", bus.count, 0);
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_empty", bus.empty, 1);
        check("flush_in_ready", bus.in_ready, 1);

        // Reset with entries queued
        for (int i = 0; i < 5; i++) push(12'd0, 2'd1, AW'(i), 1);
        check("pre_reset_count", bus.count, 5);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        check("midrst_count", bus.count, 0);
        check("midrst_cycle", bus.cycle, 0);
        check("midrst_out_valid", bus.out_valid, 0);

        // Statistics: 3 pops, 7 stalled cycles, peak occupancy 3
        for (int i = 0; i < 3; i++) push(12'd0, 2'd2, AW'(50 + i), 1);
        repeat (5) tick();
        bus.out_ready = 1'b1;
        repeat (3) tick();
        bus.out_ready = 1'b0;
        tick();
        check("stats_drained", bus.empty, 1);
`ifdef TRQ_STATS_EN
        check("stat_issued", bus.stat_issued, 3);
        check("stat_stall", bus.stat_stall, 7);
        check("stat_max_occ", bus.stat_max_occ, 3);
`else
        check("stat_issued", bus.stat_issued, 0);
        check("stat_stall", bus.stat_stall, 0);
        check("stat_max_occ", bus.stat_max_occ, 0);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        check("total_pops", pops_seen, 62);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
